current_monitor: RTL and testbench

- Downstream consumer of the TLI4970 readout stage. Takes one 13-bit signed current sample per strobe, tagged with a sensor index.
- Per sensor, it runs an exponential moving average and a debounced overcurrent trip with a latched flag.
- Filtered values, raw values, status and configuration are exposed on an Avalon-MM slave. Overcurrent flags go to the motor-control logic as a bit vector.

---
 rtl/current_monitor.sv | 188 ++++++++++++++++++
 tb/tb_current_monitor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/current_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : current_monitor
// Description : Per-sensor EMA filter and debounced, latched overcurrent trip
//               for TLI4970 samples, with an Avalon-MM status/config slave.
// Revision    : 1.0 - initial release
// ============================================================================
module current_monitor #(
    parameter int NUMBER_OF_SENSORS  = 2,
    parameter int EMA_SHIFT          = 2,
    parameter int DEFAULT_THRESHOLD  = 2000,
    parameter int DEFAULT_TRIP_COUNT = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         sample_valid,
    input  logic [7:0]                   sample_sensor,
    input  logic signed [12:0]           sample_data,
    input  logic [7:0]                   address,
    input  logic                         write,
    input  logic [31:0]                  writedata,
    input  logic                         read,
    output logic [31:0]                  readdata,
    output logic                         waitrequest,
    output logic [NUMBER_OF_SENSORS-1:0] overcurrent
);

    localparam int c_ACC_W = 13 + EMA_SHIFT;
    localparam int c_IDX_W = (NUMBER_OF_SENSORS > 1) ? $clog2(NUMBER_OF_SENSORS) : 1;

    logic [c_ACC_W-1:0]           r_acc    [NUMBER_OF_SENSORS];
    logic [12:0]                  r_raw    [NUMBER_OF_SENSORS];
    logic [7:0]                   r_exceed [NUMBER_OF_SENSORS];
    logic [12:0]                  w_filt   [NUMBER_OF_SENSORS];
    logic [NUMBER_OF_SENSORS-1:0] r_oc;
    logic [12:0]                  r_threshold;
    logic [7:0]                   r_trip_count;
    logic [31:0]                  r_sample_cnt;
    logic [31:0]                  r_idx_err_cnt;
    logic                         r_s2_valid;
    logic [c_IDX_W-1:0]           r_s2_idx;
    logic [12:0]                  r_s2_filt;
    logic                         r_rd_ack;
    logic [31:0]                  r_readdata;

    logic                         w_idx_ok;
    logic                         w_accept;
    logic [c_IDX_W-1:0]           w_idx;
    logic [c_ACC_W-1:0]           w_acc_cur;
    logic [c_ACC_W-1:0]           w_acc_next;
    logic [12:0]                  w_mag;
    logic [7:0]                   w_exc_cur;
    logic [7:0]                   w_exc_inc;
    logic                         w_over;
    logic                         w_trip;
    logic [NUMBER_OF_SENSORS-1:0] w_clr;
    logic [31:0]                  w_rdata;
    logic                         w_unused_wdata;

    assign w_unused_wdata = &{1'b0, writedata};

    assign w_idx_ok = ({24'd0, sample_sensor} < 32'(NUMBER_OF_SENSORS));
    assign w_accept = sample_valid & w_idx_ok;
    assign w_idx    = sample_sensor[c_IDX_W-1:0];

    // The accumulator is updated in place, so a back-to-back sample to the same
    // sensor always sees the previous sample's result.
    assign w_acc_cur  = r_acc[w_idx];
    assign w_acc_next = w_acc_cur
                      + {{EMA_SHIFT{sample_data[12]}}, sample_data}
                      - {{EMA_SHIFT{w_acc_cur[c_ACC_W-1]}}, w_acc_cur[c_ACC_W-1:EMA_SHIFT]};

    generate
        for (genvar i = 0; i < NUMBER_OF_SENSORS; i++) begin : g_filt
            assign w_filt[i] = r_acc[i][c_ACC_W-1:EMA_SHIFT];
        end
    endgenerate

    // Stage 1: filter update and raw capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
                r_acc[i] <= '0;
                r_raw[i] <= '0;
            end
            r_s2_valid <= 1'b0;
            r_s2_idx   <= '0;
            r_s2_filt  <= '0;
        end else begin
            r_s2_valid <= w_accept;
            if (w_accept) begin
                r_acc[w_idx] <= w_acc_next;
                r_raw[w_idx] <= sample_data;
                r_s2_idx     <= w_idx;
                r_s2_filt    <= w_acc_next[c_ACC_W-1:EMA_SHIFT];
            end
        end
    end

    // Stage 2: magnitude compare and debounce; -4096 maps to 4096 unsigned
    assign w_mag     = r_s2_filt[12] ? (13'd0 - r_s2_filt) : r_s2_filt;
    assign w_exc_cur = r_exceed[r_s2_idx];
    assign w_exc_inc = (w_exc_cur == 8'hff) ? 8'hff : (w_exc_cur + 8'd1);
    assign w_over    = (w_mag > r_threshold);
    assign w_trip    = r_s2_valid & w_over & (r_trip_count != 8'd0) & (w_exc_inc >= r_trip_count);
    assign w_clr     = (write && (address == 8'h82)) ? writedata[NUMBER_OF_SENSORS-1:0] : '0;

    // Stage-2 updates are ordered after the W1C so a simultaneous set wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
                r_exceed[i] <= '0;
            end
            r_oc <= '0;
        end else begin
            for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
                if (w_clr[i]) begin
                    r_oc[i]     <= 1'b0;
                    r_exceed[i] <= '0;
                end
            end
            if (r_s2_valid) begin
                r_exceed[r_s2_idx] <= w_over ? w_exc_inc : 8'd0;
                if (w_trip) begin
                    r_oc[r_s2_idx] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rdata = 32'hdeadbeef;
        for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
            if (address == 8'(i)) begin
                w_rdata = {{19{w_filt[i][12]}}, w_filt[i]};
            end
            if (address == 8'(64 + i)) begin
                w_rdata = {{19{r_raw[i][12]}}, r_raw[i]};
            end
        end
        case (address)
            8'h80:   w_rdata = {19'd0, r_threshold};
            8'h81:   w_rdata = {24'd0, r_trip_count};
            8'h82:   w_rdata = 32'(r_oc);
            8'h83:   w_rdata = r_sample_cnt;
            8'h84:   w_rdata = r_idx_err_cnt;
            default: ;
        endcase
    end

    // Config, counters and the two-cycle read handshake
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_threshold   <= 13'(DEFAULT_THRESHOLD);
            r_trip_count  <= 8'(DEFAULT_TRIP_COUNT);
            r_sample_cnt  <= '0;
            r_idx_err_cnt <= '0;
            r_rd_ack      <= 1'b0;
            r_readdata    <= '0;
        end else begin
            if (write) begin
                case (address)
                    8'h80:   r_threshold  <= writedata[12:0];
                    8'h81:   r_trip_count <= writedata[7:0];
                    default: ;
                endcase
            end
            if (sample_valid) begin
                if (w_idx_ok) begin
                    r_sample_cnt <= r_sample_cnt + 32'd1;
                end else if (r_idx_err_cnt != 32'hffff_ffff) begin
                    r_idx_err_cnt <= r_idx_err_cnt + 32'd1;
                end
            end
            r_rd_ack <= read & ~r_rd_ack;
            if (read && !r_rd_ack) begin
                r_readdata <= w_rdata;
            end
        end
    end

    assign waitrequest = read & ~r_rd_ack;
    assign readdata    = r_readdata;
    assign overcurrent = r_oc;

endmodule
`default_nettype wire

// File: tb/tb_current_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_current_monitor
// Description : Scoreboard bench for current_monitor with a golden EMA model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_current_monitor;

    logic               clock = 1'b0;
    logic               reset;
    logic               sample_valid;
    logic [7:0]         sample_sensor;
    logic signed [12:0] sample_data;
    logic [7:0]         address;
    logic               write;
    logic [31:0]        writedata;
    logic               read;
    logic [31:0]        readdata;
    logic               waitrequest;
    logic [1:0]         overcurrent;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q[$];
    int          m_acc[2];
    int          m_samples;
    int          exp_f[5] = '{250, 437, 578, 683, 763};

    always #5 clock = ~clock;

    current_monitor #(
        .NUMBER_OF_SENSORS (2),
        .EMA_SHIFT         (2),
        .DEFAULT_THRESHOLD (2000),
        .DEFAULT_TRIP_COUNT(3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_sensor(sample_sensor),
        .sample_data  (sample_data),
        .address      (address),
        .write        (write),
        .writedata    (writedata),
        .read         (read),
        .readdata     (readdata),
        .waitrequest  (waitrequest),
        .overcurrent  (overcurrent)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int m_filt(input int s);
        return m_acc[s] >>> 2;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; sample_valid = 1'b0; read = 1'b0; write = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        m_acc[0] = 0; m_acc[1] = 0; m_samples = 0;
    endtask

    task automatic drive_sample(input int s, input int d);
        @(negedge clock);
        sample_valid = 1'b1; sample_sensor = 8'(s); sample_data = 13'(d);
        if (s < 2) begin
            m_acc[s] = m_acc[s] + d - (m_acc[s] >>> 2);
            m_samples++;
        end
    endtask

    task automatic idle();
        @(negedge clock);
        sample_valid = 1'b0;
    endtask

    task automatic avm_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clock);
        sample_valid = 1'b0; address = a; writedata = d; write = 1'b1;
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic avm_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
        int          nw;
        bit          done;
        logic [31:0] e;
        sb_q.push_back(exp);
        @(negedge clock);
        sample_valid = 1'b0; address = a; read = 1'b1; nw = 0; done = 1'b0;
        for (int k = 0; k < 6 && !done; k++) begin
            #1;
            if (waitrequest) begin
                nw++;
                @(negedge clock);
            end else begin
                done = 1'b1;
            end
        end
        e = sb_q.pop_front();
        check(tag, readdata, e);
        check({tag, "_wait"}, 32'(nw), 32'd1);
        @(posedge clock);
        #1 read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; sample_valid = 1'b0; sample_sensor = '0; sample_data = '0;
        address = '0; write = 1'b0; writedata = '0; read = 1'b0;
        do_reset();

        check("oc_reset", {30'd0, overcurrent}, 32'd0);
        avm_read(8'h80, 32'd2000, "thr_rst");
        avm_read(8'h81, 32'd3,    "trip_rst");
        avm_read(8'h82, 32'd0,    "oc_rd_rst");
        avm_read(8'h00, 32'd0,    "filt0_rst");
        avm_read(8'h83, 32'd0,    "cnt_rst");

        // EMA step response, default threshold never reached
        for (int i = 0; i < 5; i++) begin
            drive_sample(0, 1000);
            idle();
            avm_read(8'h00, 32'(exp_f[i]), "filt0_step");
        end
        avm_read(8'h40, 32'd1000, "raw0");
        check("oc_no_trip", {30'd0, overcurrent}, 32'd0);

        // Debounced trip at the third exceed
        do_reset();
        avm_write(8'h80, 32'd500);
        avm_write(8'h81, 32'd3);
        for (int i = 0; i < 4; i++) begin
            drive_sample(0, 1000);
            idle();
        end
        idle();
        check("oc_before_5th", {30'd0, overcurrent}, 32'd0);
        drive_sample(0, 1000);
        idle();
        check("oc_t1", {30'd0, overcurrent}, 32'd0);
        idle();
        check("oc_t2", {30'd0, overcurrent}, 32'd1);

        // Latched through falling current
        for (int i = 0; i < 20; i++) drive_sample(0, 0);
        idle();
        idle();
        check("oc_latched", {30'd0, overcurrent}, 32'd1);
        avm_read(8'h00, 32'(m_filt(0)), "filt0_decay");
        avm_write(8'h82, 32'd1);
        check("oc_w1c", {30'd0, overcurrent}, 32'd0);

        // Clear coincident with a set: set wins
        avm_write(8'h80, 32'd100);
        avm_write(8'h81, 32'd1);
        drive_sample(0, 1000);
        @(negedge clock);
        sample_valid = 1'b0; address = 8'h82; writedata = 32'd1; write = 1'b1;
        check("oc_pre_set", {30'd0, overcurrent}, 32'd0);
        @(negedge clock);
        write = 1'b0;
        check("oc_set_wins", {30'd0, overcurrent}, 32'd1);
        avm_write(8'h82, 32'd3);
        check("oc_clear_all", {30'd0, overcurrent}, 32'd0);

        // Bad index, then full-scale negative burst with forwarding
        drive_sample(5, 777);
        idle();
        avm_write(8'h80, 32'd4095);
        avm_write(8'h81, 32'd1);
        for (int k = 0; k < 40; k++) begin
            drive_sample(1, -4096);
            if (k == 20) check("oc1_not_yet", {30'd0, overcurrent}, 32'd0);
        end
        for (int k = 0; k < 10; k++) begin
            drive_sample(k % 2, (k % 2 == 1) ? -4096 : 123);
        end
        idle();
        idle();
        check("oc1_trip", {30'd0, overcurrent}, 32'd2);
        avm_read(8'h84, 32'd1,              "idx_err");
        avm_read(8'h83, 32'(m_samples),     "sample_cnt");
        avm_read(8'h01, 32'(m_filt(1)),     "filt1");
        avm_read(8'h00, 32'(m_filt(0)),     "filt0_mix");
        avm_read(8'h41, 32'hfffff000,       "raw1");
        avm_read(8'h40, 32'd123,            "raw0_mix");
        avm_read(8'h90, 32'hdeadbeef,       "unmapped");
        avm_read(8'h82, 32'd2,              "oc_rd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
